// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package wb_pkg;

  localparam int unsigned XlenDefault  = 32;
  localparam int unsigned RegAwDefault = 5;
  localparam int unsigned CntW         = 16;

  // Identifies which requester won the most recent transfer.
  typedef enum logic {
    Port0 = 1'b0,
    Port1 = 1'b1
  } port_e;

  typedef struct packed {
    logic                    valid;
    logic [RegAwDefault-1:0] rd;
    logic [XlenDefault-1:0]  data;
  } wb_req_t;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == {CntW{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the two writeback requesters, the register file and the arbiter.
interface wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int unsigned XLEN   = XlenDefault,
  parameter int unsigned REG_AW = RegAwDefault
);
  logic              req0_valid;
  logic [REG_AW-1:0] req0_rd;
  logic [XLEN-1:0]   req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [REG_AW-1:0] req1_rd;
  logic [XLEN-1:0]   req1_data;
  logic              req1_ready;

  logic              RegWEn;
  logic [REG_AW-1:0] rsW;
  logic [XLEN-1:0]   dataW;

  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              pend_hit1;
  logic              pend_hit2;
  logic [CntW-1:0]   conflict_cnt;

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    output req0_ready,
    input  req1_valid, req1_rd, req1_data,
    output req1_ready,
    output RegWEn, rsW, dataW,
    input  rs1, rs2,
    output pend_hit1, pend_hit2, conflict_cnt
  );

  modport master (
    output req0_valid, req0_rd, req0_data,
    input  req0_ready,
    output req1_valid, req1_rd, req1_data,
    input  req1_ready,
    input  RegWEn, rsW, dataW,
    output rs1, rs2,
    input  pend_hit1, pend_hit2, conflict_cnt
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on conflict the port not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates core and multi-cycle writebacks onto the single register-file write port,
// with a registered output stage, read-after-write hit flags and a conflict counter.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned XLEN   = XlenDefault,
  parameter int unsigned REG_AW = RegAwDefault
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  logic [1:0]        req_vld;
  logic [1:0]        gnt;
  logic              xfer;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;

  port_e             last_grant_q, last_grant_d;
  logic              regwen_q, regwen_d;
  logic [REG_AW-1:0] rsw_q, rsw_d;
  logic [XLEN-1:0]   dataw_q, dataw_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Requests are masked during reset so no grant and no transfer can occur.
  assign req_vld = {bus.req1_valid, bus.req0_valid} & {2{~rst}};

  rr_arb2 u_rr_arb2 (
    .req  (req_vld),
    .last (last_grant_q == Port1),
    .gnt  (gnt)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign xfer           = |gnt;

  always_comb begin
    sel_rd   = bus.req0_rd;
    sel_data = bus.req0_data;
    if (gnt[1]) begin
      sel_rd   = bus.req1_rd;
      sel_data = bus.req1_data;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    regwen_d     = 1'b0;
    rsw_d        = rsw_q;
    dataw_d      = dataw_q;
    cnt_d        = cnt_q;
    if (xfer) begin
      last_grant_d = gnt[1] ? Port1 : Port0;
      // Writes to x0 are consumed but never enable the register file.
      regwen_d     = (sel_rd != '0);
      rsw_d        = sel_rd;
      dataw_d      = sel_data;
    end
    if (&req_vld) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= Port1;
      regwen_q     <= 1'b0;
      rsw_q        <= '0;
      dataw_q      <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      regwen_q     <= regwen_d;
      rsw_q        <= rsw_d;
      dataw_q      <= dataw_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.RegWEn       = regwen_q;
  assign bus.rsW          = rsw_q;
  assign bus.dataW        = dataw_q;
  assign bus.conflict_cnt = cnt_q;
  assign bus.pend_hit1    = regwen_q && (rsw_q == bus.rs1) && (bus.rs1 != '0);
  assign bus.pend_hit2    = regwen_q && (rsw_q == bus.rs2) && (bus.rs2 != '0);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and constrained-random bench for wb_arbiter with a writeback scoreboard.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if #(.XLEN(32), .REG_AW(5)) bus ();

  wb_arbiter #(.XLEN(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Stimulus for the next step.
  logic        v0 = 0, v1 = 0;
  logic [4:0]  rd0 = 0, rd1 = 0, rs1v = 0, rs2v = 0;
  logic [31:0] d0 = 0, d1 = 0;
  logic        g0, g1;

  // Reference model state.
  logic        exp_last  = 1'b1;
  logic        exp_we    = 1'b0;
  logic [4:0]  exp_rsw   = '0;
  logic [31:0] exp_dataw = '0;
  logic [15:0] exp_cnt   = '0;
  wb_req_t     sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic drive();
    bus.req0_valid = v0;
    bus.req0_rd    = rd0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_rd    = rd1;
    bus.req1_data  = d1;
    bus.rs1        = rs1v;
    bus.rs2        = rs2v;
  endtask

  // One normal cycle: check grants, push expected writeback, clock, pop and compare.
  task automatic step();
    wb_req_t e;
    drive();
    #1;
    g0 = v0 && (!v1 || exp_last);
    g1 = v1 && !g0;
    chk("ready0", {31'd0, bus.req0_ready}, {31'd0, g0});
    chk("ready1", {31'd0, bus.req1_ready}, {31'd0, g1});
    if (g0) begin
      sb.push_back('{valid: (rd0 != 0), rd: rd0, data: d0});
      exp_last = 1'b0;
    end else if (g1) begin
      sb.push_back('{valid: (rd1 != 0), rd: rd1, data: d1});
      exp_last = 1'b1;
    end else begin
      sb.push_back('{valid: 1'b0, rd: exp_rsw, data: exp_dataw});
    end
    if (v0 && v1 && exp_cnt != 16'hFFFF) exp_cnt++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    exp_we    = e.valid;
    exp_rsw   = e.rd;
    exp_dataw = e.data;
    chk("RegWEn", {31'd0, bus.RegWEn}, {31'd0, exp_we});
    chk("rsW", {27'd0, bus.rsW}, {27'd0, exp_rsw});
    chk("dataW", bus.dataW, exp_dataw);
    chk("conflict_cnt", {16'd0, bus.conflict_cnt}, {16'd0, exp_cnt});
    chk("pend_hit1", {31'd0, bus.pend_hit1},
        {31'd0, exp_we && (exp_rsw == rs1v) && (rs1v != 0)});
    chk("pend_hit2", {31'd0, bus.pend_hit2},
        {31'd0, exp_we && (exp_rsw == rs2v) && (rs2v != 0)});
  endtask

  // One cycle with reset held: no grants, everything cleared after the edge.
  task automatic reset_step();
    rst = 1'b1;
    drive();
    #1;
    chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    exp_last = 1'b1; exp_we = 1'b0; exp_rsw = '0; exp_dataw = '0; exp_cnt = '0;
    chk("rst_RegWEn", {31'd0, bus.RegWEn}, 32'd0);
    chk("rst_rsW", {27'd0, bus.rsW}, 32'd0);
    chk("rst_dataW", bus.dataW, 32'd0);
    chk("rst_cnt", {16'd0, bus.conflict_cnt}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic h0, h1;
    // Reset with both requesters asserting.
    v0 = 1; rd0 = 5'd1; d0 = 32'h11; v1 = 1; rd1 = 5'd2; d1 = 32'h22;
    #1;
    reset_step();
    reset_step();

    // Four back-to-back conflicts after reset: grants 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      v0 = 1; rd0 = 5'(i + 1); d0 = 32'hA000 + i;
      v1 = 1; rd1 = 5'(i + 9); d1 = 32'hB000 + i;
      step();
      chk("alt_gnt0", {31'd0, g0}, {31'd0, (i % 2) == 0});
    end
    chk("conflict_cnt_4", {16'd0, bus.conflict_cnt}, 32'd4);

    // Single port 0 request.
    v0 = 1; rd0 = 5'd5; d0 = 32'hDEADBEEF; v1 = 0;
    step();
    chk("single_rsW", {27'd0, bus.rsW}, 32'd5);
    chk("single_dataW", bus.dataW, 32'hDEADBEEF);

    // Idle: RegWEn drops, rsW/dataW hold.
    v0 = 0;
    step();

    // x0 write on port 1.
    v1 = 1; rd1 = 5'd0; d1 = 32'h1234;
    step();
    chk("x0_RegWEn", {31'd0, bus.RegWEn}, 32'd0);

    // Hazard flags against an in-flight write to x7.
    v1 = 1; rd1 = 5'd7; d1 = 32'hCAFE; rs1v = 5'd7; rs2v = 5'd0;
    step();
    chk("hazard_hit1", {31'd0, bus.pend_hit1}, 32'd1);
    chk("hazard_hit2", {31'd0, bus.pend_hit2}, 32'd0);
    v1 = 0; rs2v = 5'd7;
    step();

    // Reset right after an accepted request discards it.
    v0 = 1; rd0 = 5'd9; d0 = 32'h99;
    step();
    rd0 = 5'd10; d0 = 32'hAA;
    reset_step();
    v0 = 0;
    step();

    // Random traffic; an ungranted requester holds its request.
    h0 = 0; h1 = 0;
    for (int i = 0; i < 60; i++) begin
      if (!h0) begin v0 = 1'($urandom); rd0 = 5'($urandom); d0 = $urandom; end
      if (!h1) begin v1 = 1'($urandom); rd1 = 5'($urandom); d1 = $urandom; end
      rs1v = 5'($urandom_range(0, 3)) + (exp_rsw & 5'h1C);
      rs2v = 5'($urandom);
      step();
      h0 = v0 && !g0;
      h1 = v1 && !g1;
    end

    // Saturation: hold both valids well past the counter range.
    v0 = 1; rd0 = 5'd3; d0 = 32'h3; v1 = 1; rd1 = 5'd4; d1 = 32'h4;
    drive();
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_cnt", {16'd0, bus.conflict_cnt}, 32'h0000FFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", {16'd0, bus.conflict_cnt}, 32'h0000FFFF);
    v1 = 0;
    drive();
    @(posedge clk);
    #1;
    chk("sat_after", {16'd0, bus.conflict_cnt}, 32'h0000FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
